// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port arbiter in front of a single-port read-first RAM.
//   p0  : read-only fetch port (req/addr -> gnt, rvalid/rdata)
//   p1  : load/store port with byte strobes; partial writes become a
//         read-modify-write sequence (IDLE -> RMW_RD -> RMW_WR -> IDLE)
//   ram : addr/din/we/regce out, dout in; read data appears RD_LATENCY
//         cycles after the address is presented
//   busy: high while a read-modify-write owns the RAM
// Optional macro RAM_ARB_RR_EN: round-robin arbitration instead of the
// default fixed priority (p1 wins every conflict).
module ram_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                p0_req,
    input  logic [ADDR_W-1:0]   p0_addr,
    output logic                p0_gnt,
    output logic                p0_rvalid,
    output logic [DATA_W-1:0]   p0_rdata,
    input  logic                p1_req,
    input  logic                p1_we,
    input  logic [DATA_W/8-1:0] p1_wstrb,
    input  logic [ADDR_W-1:0]   p1_addr,
    input  logic [DATA_W-1:0]   p1_wdata,
    output logic                p1_gnt,
    output logic                p1_rvalid,
    output logic [DATA_W-1:0]   p1_rdata,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_din,
    output logic                ram_we,
    output logic                ram_regce,
    input  logic [DATA_W-1:0]   ram_dout,
    output logic                busy
);
    localparam int NB = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, RMW_RD, RMW_WR} state_t;

    state_t              state;
    logic [1:0]          cnt;
    logic [ADDR_W-1:0]   rmw_addr;
    logic [DATA_W-1:0]   rmw_wdata;
    logic [DATA_W-1:0]   rmw_old;
    logic [NB-1:0]       rmw_strb;
    logic [DATA_W-1:0]   merged;

    // Read response pipeline: valid bit and owning port (1 = p1) per stage.
    logic [RD_LATENCY-1:0] vld_pipe;
    logic [RD_LATENCY-1:0] pid_pipe;

    logic idle, pick_p1, strb_full, strb_none, p1_part, issue_rd;

    assign idle      = (state == IDLE) && !rst;
    assign strb_full = &p1_wstrb;
    assign strb_none = ~|p1_wstrb;

`ifdef RAM_ARB_RR_EN
    logic last_p1;
    // On conflict the port that was not granted most recently wins.
    assign pick_p1 = p1_req && (!p0_req || !last_p1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         last_p1 <= 1'b0;
        else if (p1_gnt) last_p1 <= 1'b1;
        else if (p0_gnt) last_p1 <= 1'b0;
    end
`else
    assign pick_p1 = p1_req;
`endif

    assign p1_gnt   = idle && pick_p1;
    assign p0_gnt   = idle && p0_req && !pick_p1;
    assign p1_part  = p1_gnt && p1_we && !strb_full && !strb_none;
    // Only plain reads produce a response; the RMW's internal read does not.
    assign issue_rd = p0_gnt || (p1_gnt && !p1_we);

    always_comb begin
        merged = rmw_old;
        for (int i = 0; i < NB; i++)
            if (rmw_strb[i]) merged[i*8 +: 8] = rmw_wdata[i*8 +: 8];
    end

    assign ram_regce = 1'b1;

    always_comb begin
        ram_addr = '0;
        ram_din  = '0;
        ram_we   = 1'b0;
        if (!rst) begin
            if (state == RMW_WR) begin
                ram_addr = rmw_addr;
                ram_din  = merged;
                ram_we   = 1'b1;
            end else if (p0_gnt) begin
                ram_addr = p0_addr;
            end else if (p1_gnt && !(p1_we && strb_none)) begin
                ram_addr = p1_addr;
                if (p1_we && strb_full) begin
                    ram_din = p1_wdata;
                    ram_we  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rmw_addr  <= '0;
            rmw_wdata <= '0;
            rmw_strb  <= '0;
            rmw_old   <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (p1_part) begin
                    rmw_addr  <= p1_addr;
                    rmw_wdata <= p1_wdata;
                    rmw_strb  <= p1_wstrb;
                    cnt       <= '0;
                    busy      <= 1'b1;
                    state     <= RMW_RD;
                end
                RMW_RD: begin
                    // Old word is on ram_dout in the last RMW_RD cycle.
                    if (cnt == 2'(RD_LATENCY - 1)) begin
                        rmw_old <= ram_dout;
                        state   <= RMW_WR;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                RMW_WR: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            pid_pipe <= '0;
        end else begin
            vld_pipe[0] <= issue_rd;
            pid_pipe[0] <= p1_gnt;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                pid_pipe[i] <= pid_pipe[i-1];
            end
        end
    end

    assign p0_rvalid = vld_pipe[RD_LATENCY-1] && !pid_pipe[RD_LATENCY-1];
    assign p1_rvalid = vld_pipe[RD_LATENCY-1] &&  pid_pipe[RD_LATENCY-1];
    assign p0_rdata  = p0_rvalid ? ram_dout : '0;
    assign p1_rdata  = p1_rvalid ? ram_dout : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: two instances (RD_LATENCY 1 and 2), each with its
// own read-first RAM model, exercised one after the other by the same
// directed sequence. Reads are scored against a shadow memory.
module tb_ram_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic [1:0]       p0_req, p0_gnt, p0_rvalid;
    logic [1:0]       p1_req, p1_we, p1_gnt, p1_rvalid;
    logic [1:0]       ram_we, ram_regce, busy;
    logic [1:0][9:0]  p0_addr, p1_addr, ram_addr;
    logic [1:0][31:0] p0_rdata, p1_wdata, p1_rdata, ram_din, ram_dout;
    logic [1:0][3:0]  p1_wstrb;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ram_arbiter #(.ADDR_W(10), .DATA_W(32), .RD_LATENCY(g + 1)) dut (
            .clk(clk), .rst(rst),
            .p0_req(p0_req[g]), .p0_addr(p0_addr[g]), .p0_gnt(p0_gnt[g]),
            .p0_rvalid(p0_rvalid[g]), .p0_rdata(p0_rdata[g]),
            .p1_req(p1_req[g]), .p1_we(p1_we[g]), .p1_wstrb(p1_wstrb[g]),
            .p1_addr(p1_addr[g]), .p1_wdata(p1_wdata[g]), .p1_gnt(p1_gnt[g]),
            .p1_rvalid(p1_rvalid[g]), .p1_rdata(p1_rdata[g]),
            .ram_addr(ram_addr[g]), .ram_din(ram_din[g]), .ram_we(ram_we[g]),
            .ram_regce(ram_regce[g]), .ram_dout(ram_dout[g]), .busy(busy[g])
        );
    end

    // Read-first RAM models; instance 1 has an extra output register.
    logic [31:0] mem [2][1024];
    logic [31:0] q1 [2];
    logic [31:0] q2;
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (ram_regce[k]) q1[k] <= mem[k][ram_addr[k]];
            if (ram_we[k])    mem[k][ram_addr[k]] <= ram_din[k];
        end
        q2 <= q1[1];
    end
    assign ram_dout[0] = q1[0];
    assign ram_dout[1] = q2;

    typedef struct {
        int          inst;
        int          port;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [2][1024];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    logic [1:0]  s_p0_gnt, s_p1_gnt, s_busy, s_ram_we;
    logic        any_we;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (st[i]) r[i*8 +: 8] = wd[i*8 +: 8];
        return r;
    endfunction

    // One clock cycle: sample at the falling edge, score responses, record
    // grants into the scoreboard/shadow memory, then advance past the edge.
    task automatic cycle();
        @(negedge clk);
        s_p0_gnt = p0_gnt;
        s_p1_gnt = p1_gnt;
        s_busy   = busy;
        s_ram_we = ram_we;
        any_we   = any_we | (|ram_we);
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 2; p++) begin
                logic        ex;
                logic        rv;
                logic [31:0] rd;
                ex = (sb.size() > 0) && sb[0].inst == k && sb[0].port == p && sb[0].due == cyc;
                rv = p ? p1_rvalid[k] : p0_rvalid[k];
                rd = p ? p1_rdata[k]  : p0_rdata[k];
                chk($sformatf("rvalid i%0d p%0d c%0d", k, p, cyc), 32'(rv), 32'(ex));
                chk($sformatf("rdata i%0d p%0d c%0d", k, p, cyc), rd, ex ? sb[0].data : 32'h0);
            end
        end
        if (sb.size() > 0 && sb[0].due <= cyc) void'(sb.pop_front());
        for (int k = 0; k < 2; k++) begin
            chk("one_gnt", 32'(p0_gnt[k] & p1_gnt[k]), 32'h0);
            if (p0_gnt[k]) sb.push_back('{k, 0, model[k][p0_addr[k]], cyc + k + 1});
            if (p1_gnt[k]) begin
                if (!p1_we[k]) sb.push_back('{k, 1, model[k][p1_addr[k]], cyc + k + 1});
                else model[k][p1_addr[k]] = merge(model[k][p1_addr[k]], p1_wdata[k], p1_wstrb[k]);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic idle_inputs();
        p0_req = '0; p0_addr = '0; p1_req = '0; p1_we = '0;
        p1_wstrb = '0; p1_addr = '0; p1_wdata = '0;
    endtask

    task automatic reset_dut(input int k);
        idle_inputs();
        rst = 1'b1;
        sb.delete();
        cycle();
        cycle();
        chk("rst_busy", 32'(busy[k]), 0);
        chk("rst_ram_we", 32'(ram_we[k]), 0);
        chk("rst_ram_addr", 32'(ram_addr[k]), 0);
        chk("rst_ram_din", ram_din[k], 0);
        chk("rst_rvalid", 32'({p0_rvalid[k], p1_rvalid[k]}), 0);
        rst = 1'b0;
    endtask

    // Returns how many cycles the request was held before its grant.
    task automatic read0(input int k, input logic [9:0] a, output int waited);
        p0_req[k] = 1'b1; p0_addr[k] = a; waited = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(); waited++;
            if (s_p0_gnt[k]) break;
        end
        chk("p0_gnt_timeout", 32'(s_p0_gnt[k]), 1);
        p0_req[k] = 1'b0;
    endtask

    task automatic write1(input int k, input logic [9:0] a, input logic [31:0] d, input logic [3:0] st);
        p1_req[k] = 1'b1; p1_we[k] = 1'b1; p1_addr[k] = a; p1_wdata[k] = d; p1_wstrb[k] = st;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (s_p1_gnt[k]) break;
        end
        chk("p1_gnt_timeout", 32'(s_p1_gnt[k]), 1);
        p1_req[k] = 1'b0; p1_we[k] = 1'b0;
    endtask

    task automatic run_suite(input int k);
        int w, n;
        int lat;
        int gseq [4];
        int gexp [4];
        lat = k + 1;
        reset_dut(k);

        // Simple read, granted in the first requesting cycle.
        write1(k, 10'h010, 32'hDEADBEEF, 4'hF);
        chk("full_wr_we", 32'(s_ram_we[k]), 1);
        read0(k, 10'h010, w);
        chk("p0_gnt_latency", 32'(w), 1);
        drain(3);

        // Zero strobe: granted but nothing reaches the RAM.
        write1(k, 10'h010, 32'h0, 4'h0);
        chk("zero_strb_we", 32'(s_ram_we[k]), 0);
        cycle();
        chk("zero_strb_busy", 32'(s_busy[k]), 0);

        // Partial write merge and busy duration.
        write1(k, 10'h020, 32'h11223344, 4'hF);
        write1(k, 10'h020, 32'h0000AA00, 4'h2);
        chk("part_wr_grant_we", 32'(s_ram_we[k]), 0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (s_busy[k]) n++; else break;
        end
        chk("rmw_busy_cycles", 32'(n), 32'(lat + 1));
        chk("rmw_mem", mem[k][10'h020], 32'h1122AA44);
        read0(k, 10'h020, w);
        drain(3);

        // Back-to-back reads return in order, one per cycle.
        write1(k, 10'h001, 32'hA0000001, 4'hF);
        write1(k, 10'h002, 32'hA0000002, 4'hF);
        write1(k, 10'h003, 32'hA0000003, 4'hF);
        p0_req[k] = 1'b1;
        for (int a = 1; a <= 3; a++) begin
            p0_addr[k] = 10'(a);
            cycle();
            chk("b2b_gnt", 32'(s_p0_gnt[k]), 1);
        end
        p0_req[k] = 1'b0;
        drain(lat + 2);

        // Read in flight across a partial write; p0 held off during the RMW.
        p0_req[k] = 1'b1; p0_addr[k] = 10'h001;
        cycle();
        chk("pre_rmw_p0_gnt", 32'(s_p0_gnt[k]), 1);
        p0_addr[k] = 10'h020;
        p1_req[k] = 1'b1; p1_we[k] = 1'b1; p1_addr[k] = 10'h020;
        p1_wdata[k] = 32'h55000000; p1_wstrb[k] = 4'h8;
        cycle();
        chk("rmw_p1_gnt", 32'({s_p0_gnt[k], s_p1_gnt[k]}), 32'h1);
        p1_req[k] = 1'b0; p1_we[k] = 1'b0;
        for (int i = 0; i < lat + 1; i++) begin
            cycle();
            chk("rmw_holdoff_gnt", 32'(s_p0_gnt[k]), 0);
            chk("rmw_holdoff_busy", 32'(s_busy[k]), 1);
        end
        cycle();
        chk("post_rmw_p0_gnt", 32'(s_p0_gnt[k]), 1);
        p0_req[k] = 1'b0;
        drain(lat + 2);

        // Conflict resolution right after reset.
        reset_dut(k);
        p0_req[k] = 1'b1; p0_addr[k] = 10'h010;
        p1_req[k] = 1'b1; p1_we[k] = 1'b0; p1_addr[k] = 10'h020;
        for (int i = 0; i < 4; i++) begin
            cycle();
            gseq[i] = s_p1_gnt[k] ? 1 : (s_p0_gnt[k] ? 0 : 2);
        end
        idle_inputs();
`ifdef RAM_ARB_RR_EN
        gexp = '{1, 0, 1, 0};
`else
        gexp = '{1, 1, 1, 1};
`endif
        for (int i = 0; i < 4; i++) chk($sformatf("arb_seq%0d", i), 32'(gseq[i]), 32'(gexp[i]));
        drain(lat + 2);

        // Reset drops an in-flight read.
        p0_req[k] = 1'b1; p0_addr[k] = 10'h002;
        cycle();
        chk("inflight_gnt", 32'(s_p0_gnt[k]), 1);
        p0_req[k] = 1'b0;
        rst = 1'b1;
        sb.delete();
        cycle();
        rst = 1'b0;
        drain(lat + 2);

        // Reset during RMW_RD abandons the write; grants resume at once.
        write1(k, 10'h030, 32'hCAFEF00D, 4'hF);
        any_we = 1'b0;
        write1(k, 10'h030, 32'h000000FF, 4'h1);
        model[k][10'h030] = 32'hCAFEF00D;
        p0_req[k] = 1'b1; p0_addr[k] = 10'h030;
        rst = 1'b1;
        #1;
        chk("rst_async_busy", 32'(busy[k]), 0);
        chk("rst_async_gnt", 32'(p0_gnt[k]), 0);
        chk("rst_async_we", 32'(ram_we[k]), 0);
        sb.delete();
        cycle();
        rst = 1'b0;
        cycle();
        chk("resume_gnt", 32'(s_p0_gnt[k]), 1);
        p0_req[k] = 1'b0;
        drain(lat + 3);
        chk("rmw_abort_we", 32'(any_we), 0);
        chk("rmw_abort_mem", mem[k][10'h030], 32'hCAFEF00D);
        chk("rmw_abort_busy", 32'(s_busy[k]), 0);
    endtask

    initial begin
        any_we = 1'b0;
        idle_inputs();
        rst = 1'b1;
        #1;
        chk("rst_now_gnt", 32'({p0_gnt, p1_gnt}), 0);
        run_suite(0);
        run_suite(1);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
